ad5662_spi_rx: RTL and testbench

- Receive-side counterpart of the AD5662 SPI transmitter used by the VCTCXO discipline loop.
- Oversamples SCLK/MOSI/SYNC_N in the 200 MHz loop clock domain and decodes 24-bit AD5662 frames into DAC code and power-down mode.
- Flags aborted frames and a stale DAC stream.
- Used as an on-chip loopback monitor for the DAC control word, and as the DAC model in loop testbenches.

---
 rtl/ad5662_spi_rx.sv | 201 ++++++++++++++++++++
 tb/tb_ad5662_spi_rx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ad5662_spi_rx.sv
// AD5662 SPI frame receiver: oversamples SCLK/MOSI/SYNC_N in the loop clock domain,
// decodes 24-bit frames into DAC code and power-down mode, and tracks aborted/stale frames.
module ad5662_spi_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        sync_n,
    output logic [15:0] dac_val,
    output logic [1:0]  pd_mode,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [15:0] frame_cnt,
    output logic [7:0]  err_cnt,
    output logic        stale
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [27:0] TO_LIM = 28'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sync_n_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_sync_n_prev;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_bit_cnt;
    logic [23:0] r_sr;
    logic        r_done;
    logic        r_abort;
    logic [27:0] r_to_cnt;
    logic [27:0] w_to_next;

    logic w_sclk_cur;
    logic w_sync_n_cur;
    logic w_mosi_cur;
    logic w_sclk_fall;
    logic w_sync_fall;
    logic w_sync_rise;
    logic w_shift;
    logic w_done;
    logic w_abort;
    logic w_clr_cnt;

    // Synchronizer chains plus one edge-detect flop per control input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync   <= '1;
            r_sync_n_sync <= '1;
            r_mosi_sync   <= '0;
            r_sclk_prev   <= 1'b1;
            r_sync_n_prev <= 1'b1;
        end else begin
            r_sclk_sync[0]   <= sclk;
            r_sync_n_sync[0] <= sync_n;
            r_mosi_sync[0]   <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sclk_sync[i]   <= r_sclk_sync[i-1];
                r_sync_n_sync[i] <= r_sync_n_sync[i-1];
                r_mosi_sync[i]   <= r_mosi_sync[i-1];
            end
            r_sclk_prev   <= w_sclk_cur;
            r_sync_n_prev <= w_sync_n_cur;
        end
    end

    // MOSI is taken from the same stage as the SCLK "current" value so both see equal delay.
    assign w_sclk_cur   = r_sclk_sync[SYNC_STAGES-1];
    assign w_sync_n_cur = r_sync_n_sync[SYNC_STAGES-1];
    assign w_mosi_cur   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_fall  = r_sclk_prev & ~w_sclk_cur;
    assign w_sync_fall  = r_sync_n_prev & ~w_sync_n_cur;
    assign w_sync_rise  = ~r_sync_n_prev & w_sync_n_cur;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; a final SCLK edge coinciding with SYNC_N rising still completes the frame.
    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        w_clr_cnt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sync_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_clr_cnt   = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_sclk_fall) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 5'd23) begin
                        w_done      = 1'b1;
                        w_state_nxt = w_sync_rise ? ST_IDLE : ST_HOLD;
                    end else if (w_sync_rise) begin
                        w_abort     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else if (w_sync_rise) begin
                    w_abort     = (r_bit_cnt != 5'd0);
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (w_sync_rise) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift register, bit counter and one-cycle completion/abort flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt <= 5'd0;
            r_sr      <= 24'd0;
            r_done    <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            if (w_clr_cnt) begin
                r_bit_cnt <= 5'd0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
            if (w_shift) begin
                r_sr <= {r_sr[22:0], w_mosi_cur};
            end else begin
                r_sr <= r_sr;
            end
            r_done  <= w_done;
            r_abort <= w_abort;
        end
    end

    assign w_to_next = (r_to_cnt == 28'hFFF_FFFF) ? r_to_cnt : r_to_cnt + 28'd1;

    // Registered outputs, frame/error counters and stale timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dac_val     <= 16'd32767;
            pd_mode     <= 2'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_cnt   <= 16'd0;
            err_cnt     <= 8'd0;
            stale       <= 1'b0;
            r_to_cnt    <= 28'd0;
        end else begin
            frame_valid <= r_done;
            frame_err   <= r_abort;
            if (r_done) begin
                dac_val   <= r_sr[15:0];
                pd_mode   <= r_sr[17:16];
                frame_cnt <= frame_cnt + 16'd1;
                r_to_cnt  <= 28'd0;
                stale     <= 1'b0;
            end else begin
                r_to_cnt  <= w_to_next;
                stale     <= (w_to_next >= TO_LIM);
            end
            if (r_abort && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end else begin
                err_cnt <= err_cnt;
            end
        end
    end

endmodule

// File: tb/tb_ad5662_spi_rx.sv
// Directed, table-driven bench for ad5662_spi_rx with SCLK = clk/8.
module tb_ad5662_spi_rx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sclk = 1'b1;
    logic        mosi = 1'b0;
    logic        sync_n = 1'b1;
    logic [15:0] dac_val;
    logic [1:0]  pd_mode;
    logic        frame_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
    logic        stale;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int fv_cyc = 0;
    int t24 = 0;
    logic fv_stale = 1'b1;

    ad5662_spi_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .sync_n(sync_n),
        .dac_val(dac_val), .pd_mode(pd_mode), .frame_valid(frame_valid),
        .frame_err(frame_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .stale(stale)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            fv_cnt   = fv_cnt + 1;
            fv_cyc   = cyc;
            fv_stale = stale;
        end
        if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits, input int gap);
        @(negedge clk);
        sync_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < nbits; i++) begin
            mosi = data[nbits-1-i];
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
            if (i == 23) t24 = cyc;
            wait_clk(4);
        end
        sclk = 1'b1;
        wait_clk(4);
        sync_n = 1'b1;
        wait_clk(gap);
    endtask

    typedef struct {
        logic [23:0] word;
        int          gap;
        logic [15:0] dac;
        logic [1:0]  pd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int fv0;
        int fe0;
        logic [15:0] exp_fc;

        vecs[0] = '{24'h00_8123, 12, 16'h8123, 2'd0};
        vecs[1] = '{24'h03_FFFF,  8, 16'hFFFF, 2'd3};
        vecs[2] = '{24'h00_0000, 12, 16'h0000, 2'd0};
        vecs[3] = '{24'hFC_5A5A, 12, 16'h5A5A, 2'd0};
        vecs[4] = '{24'h02_ABCD, 12, 16'hABCD, 2'd2};
        vecs[5] = '{24'h01_C3C3, 12, 16'hC3C3, 2'd1};

        wait_clk(3);
        check("rst_dac", 32'(dac_val), 32'h7FFF);
        check("rst_pd", 32'(pd_mode), 32'h0);
        check("rst_fv", 32'(frame_valid), 32'h0);
        check("rst_fe", 32'(frame_err), 32'h0);
        check("rst_fcnt", 32'(frame_cnt), 32'h0);
        check("rst_ecnt", 32'(err_cnt), 32'h0);
        check("rst_stale", 32'(stale), 32'h0);

        // Stale timeout: 998 edges after release still clear, 999th edge sets it.
        reset_n = 1'b1;
        wait_clk(998);
        check("stale_998", 32'(stale), 32'h0);
        wait_clk(1);
        check("stale_999", 32'(stale), 32'h1);

        // SYNC_N low/high with no SCLK edges: silent.
        fv0 = fv_cnt; fe0 = fe_cnt;
        @(negedge clk); sync_n = 1'b0;
        wait_clk(8);
        sync_n = 1'b1;
        wait_clk(8);
        check("empty_fv", 32'(fv_cnt - fv0), 32'd0);
        check("empty_fe", 32'(fe_cnt - fe0), 32'd0);
        check("empty_ecnt", 32'(err_cnt), 32'd0);

        // Abort after 10 bits.
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_frame(32'h00_8123, 10, 12);
        check("abort_fe", 32'(fe_cnt - fe0), 32'd1);
        check("abort_fv", 32'(fv_cnt - fv0), 32'd0);
        check("abort_ecnt", 32'(err_cnt), 32'd1);
        check("abort_dac", 32'(dac_val), 32'h7FFF);
        check("abort_fcnt", 32'(frame_cnt), 32'd0);
        check("stale_pre", 32'(stale), 32'h1);

        exp_fc = 16'd0;
        for (int v = 0; v < 6; v++) begin
            fv0 = fv_cnt; fe0 = fe_cnt;
            send_frame(32'(vecs[v].word), 24, vecs[v].gap);
            exp_fc = exp_fc + 16'd1;
            check($sformatf("v%0d_fv", v), 32'(fv_cnt - fv0), 32'd1);
            check($sformatf("v%0d_fe", v), 32'(fe_cnt - fe0), 32'd0);
            check($sformatf("v%0d_lat", v), 32'(fv_cyc - t24), 32'd4);
            check($sformatf("v%0d_dac", v), 32'(dac_val), 32'(vecs[v].dac));
            check($sformatf("v%0d_pd", v), 32'(pd_mode), 32'(vecs[v].pd));
            check($sformatf("v%0d_fcnt", v), 32'(frame_cnt), 32'(exp_fc));
            if (v == 0) begin
                check("stale_at_fv", 32'(fv_stale), 32'h0);
                check("stale_after", 32'(stale), 32'h0);
            end
        end

        // 28 SCLK edges: only the first 24 bits count.
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_frame(32'h014_321F, 28, 12);
        exp_fc = exp_fc + 16'd1;
        check("long_fv", 32'(fv_cnt - fv0), 32'd1);
        check("long_fe", 32'(fe_cnt - fe0), 32'd0);
        check("long_dac", 32'(dac_val), 32'h4321);
        check("long_pd", 32'(pd_mode), 32'h1);
        check("long_fcnt", 32'(frame_cnt), 32'(exp_fc));

        // Error counter saturation.
        fe0 = fe_cnt;
        for (int k = 0; k < 260; k++) send_frame(32'h1, 1, 8);
        check("sat_fe", 32'(fe_cnt - fe0), 32'd260);
        check("sat_ecnt", 32'(err_cnt), 32'd255);
        check("sat_dac", 32'(dac_val), 32'h4321);

        // Reset mid-frame after 12 bits, then a clean frame.
        @(negedge clk);
        sync_n = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 12; i++) begin
            mosi = i[0];
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
            wait_clk(4);
        end
        sclk = 1'b1;
        reset_n = 1'b0;
        wait_clk(3);
        check("mid_rst_dac", 32'(dac_val), 32'h7FFF);
        check("mid_rst_ecnt", 32'(err_cnt), 32'd0);
        check("mid_rst_fcnt", 32'(frame_cnt), 32'd0);
        reset_n = 1'b1;
        fv0 = fv_cnt; fe0 = fe_cnt;
        wait_clk(8);
        sync_n = 1'b1;
        wait_clk(8);
        check("post_rst_fe", 32'(fe_cnt - fe0), 32'd0);
        send_frame(32'h00_1234, 24, 12);
        check("post_rst_fv", 32'(fv_cnt - fv0), 32'd1);
        check("post_rst_dac", 32'(dac_val), 32'h1234);
        check("post_rst_pd", 32'(pd_mode), 32'h0);
        check("post_rst_ecnt", 32'(err_cnt), 32'd0);
        check("post_rst_fcnt", 32'(frame_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
